// File: rtl/seq_multiplier_32_pkg.sv
// rtl/seq_multiplier_32_pkg.sv - shared constants and state encoding for the sequential multiplier
package seq_multiplier_32_pkg;

  // Default operand width; the product is twice this wide.
  localparam int MUL_WIDTH = 32;

  // Iteration counter width; must be able to hold MUL_WIDTH.
  localparam int MUL_CNT_W = 6;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mul_state_t;

endpackage

// File: rtl/_32bit_adder.sv
// rtl/_32bit_adder.sv - ripple-style W-bit adder with carry in and carry out
module _32bit_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  // Widen by one bit so the carry out lands in the top position.
  assign total       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/seq_multiplier_32.sv
// rtl/seq_multiplier_32.sv - multicycle shift-and-add multiplier for mult/multu into HI/LO
module seq_multiplier_32
  import seq_multiplier_32_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Count value seen during the final RUN iteration.
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic             neg;

  // Negation adders: operand magnitudes in IDLE, 64-bit product negate in FIN.
  logic [WIDTH-1:0] x_a;
  logic [WIDTH-1:0] x_sum;
  logic             x_cout;
  logic [WIDTH-1:0] y_a;
  logic [WIDTH-1:0] y_sum;
  logic             y_cin;
  logic             unused_y_cout;

  // Accumulation adder used once per RUN iteration.
  logic [WIDTH-1:0] acc_b;
  logic [WIDTH-1:0] acc_sum;
  logic             acc_cout;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Steer the negation adders: operands while idle, the product halves in FIN.
  always_comb begin
    x_a   = ~A;
    y_a   = ~B;
    y_cin = 1'b1;
    if (state == ST_FIN) begin
      x_a   = ~lower;
      y_a   = ~upper;
      y_cin = x_cout;
    end
  end

  _32bit_adder #(.W(WIDTH)) u_neg_lo (
    .a    (x_a),
    .b    ({WIDTH{1'b0}}),
    .cin  (1'b1),
    .sum  (x_sum),
    .cout (x_cout)
  );

  _32bit_adder #(.W(WIDTH)) u_neg_hi (
    .a    (y_a),
    .b    ({WIDTH{1'b0}}),
    .cin  (y_cin),
    .sum  (y_sum),
    .cout (unused_y_cout)
  );

  // Only negative signed operands are replaced by their two's-complement magnitude.
  assign a_mag = (is_signed && A[WIDTH-1]) ? x_sum : A;
  assign b_mag = (is_signed && B[WIDTH-1]) ? y_sum : B;

  // Add the multiplicand only when the current multiplier bit is set.
  assign acc_b = lower[0] ? mcand : {WIDTH{1'b0}};

  _32bit_adder #(.W(WIDTH)) u_acc (
    .a    (upper),
    .b    (acc_b),
    .cin  (1'b0),
    .sum  (acc_sum),
    .cout (acc_cout)
  );

  // Controller and datapath registers; the adder carry is shifted straight into the upper half.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
      mcand <= '0;
      upper <= '0;
      lower <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= a_mag;
            lower <= b_mag;
            upper <= '0;
            neg   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RUN: begin
          upper <= {acc_cout, acc_sum[WIDTH-1:1]};
          lower <= {acc_sum[0], lower[WIDTH-1:1]};
          count <= count + CNT_W'(1);
          if (count == LAST_COUNT) begin
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          hi    <= neg ? y_sum : upper;
          lo    <= neg ? x_sum : lower;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_32.sv
// tb/tb_seq_multiplier_32.sv - self-checking bench for seq_multiplier_32 against a product-level model
module tb_seq_multiplier_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  seq_multiplier_32 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cycle  = 0;

  bit          m_active   = 1'b0;
  int          m_age      = 0;
  logic [63:0] m_prod     = 64'd0;
  logic [63:0] m_result   = 64'd0;
  bit          exp_busy   = 1'b0;
  bit          exp_done   = 1'b0;
  int          m_done_cnt = 0;
  int          dut_done_cnt = 0;
  bit          checking   = 1'b0;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] wa;
    logic [63:0] wb;
    if (s) begin
      wa = {{32{a[31]}}, a};
      wb = {{32{b[31]}}, b};
    end else begin
      wa = {32'd0, a};
      wb = {32'd0, b};
    end
    return wa * wb;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Reference: a start seen while idle yields done 33 edges later; busy spans that whole window.
  always @(posedge clk) begin
    cycle++;
    if (reset) begin
      m_active = 1'b0;
      m_age    = 0;
      m_result = 64'd0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else if (m_active) begin
      m_age++;
      exp_busy = 1'b1;
      exp_done = (m_age == 33);
      if (m_age == 33) begin
        m_result = m_prod;
        m_active = 1'b0;
        m_done_cnt++;
      end
    end else begin
      exp_done = 1'b0;
      if (start) begin
        m_prod   = ref_prod(A, B, is_signed);
        m_active = 1'b1;
        m_age    = 0;
        exp_busy = 1'b1;
      end else begin
        exp_busy = 1'b0;
      end
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) dut_done_cnt++;
    if (checking) begin
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      check("done", {63'd0, done}, {63'd0, exp_done});
      check("hi", {32'd0, hi}, {32'd0, m_result[63:32]});
      check("lo", {32'd0, lo}, {32'd0, m_result[31:0]});
    end
  end

  task automatic wait_done(output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] lit_hi, input logic [31:0] lit_lo);
    int n;
    bit got;
    check({name, "_model"}, ref_prod(a, b, s), {lit_hi, lit_lo});
    @(negedge clk);
    A = a;
    B = b;
    is_signed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, got);
    check({name, "_latency"}, 64'(n), 64'd33);
    check({name, "_hi"}, {32'd0, hi}, {32'd0, lit_hi});
    check({name, "_lo"}, {32'd0, lo}, {32'd0, lit_lo});
  endtask

  initial begin
    int n;
    bit got;
    int cycles;
    int target;

    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    A         = 32'd0;
    B         = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    checking = 1'b1;

    run_mul("u3x5", 32'd3, 32'd5, 1'b0, 32'h0000_0000, 32'h0000_000F);
    run_mul("u_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mul("s_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
    run_mul("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_mul("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);

    // A start while busy must not disturb the operation in flight.
    @(negedge clk);
    A = 32'd2;
    B = 32'd3;
    is_signed = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    A = 32'd9;
    B = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 32'd0;
    B = 32'd0;
    wait_done(n, got);
    check("ign_done", {63'd0, got}, 64'd1);
    check("ign_hi", {32'd0, hi}, 64'd0);
    check("ign_lo", {32'd0, lo}, 64'd6);
    run_mul("after_done", 32'h0000_1234, 32'h0001_0000, 1'b0, 32'h0000_0000, 32'h1234_0000);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    A = 32'd12345;
    B = 32'd678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_mul("u4x4", 32'd4, 32'd4, 1'b0, 32'h0000_0000, 32'h0000_0010);

    // Free-running random traffic, including start pulses while busy.
    cycles = 0;
    target = m_done_cnt + 1000;
    while (m_done_cnt < target && cycles < 60000) begin
      @(negedge clk);
      start     = ($urandom_range(2) == 0);
      A         = rand_op();
      B         = rand_op();
      is_signed = 1'($urandom_range(1));
      cycles++;
    end
    start = 1'b0;
    check("random_ops", 64'(m_done_cnt), 64'(target));
    repeat (40) @(negedge clk);
    check("done_pulses", 64'(dut_done_cnt), 64'(m_done_cnt));

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_32.md
Name: seq_multiplier_32

Overview:
- Multicycle 32x32 shift-and-add multiplier for MIPS mult/multu; writes a 64-bit product to HI/LO.
- Builds the product by repeated addition, one multiplier bit per cycle, through a single 32-bit adder.
- Sits beside the ALU. Control holds the pipeline while busy is high and latches HI/LO when done pulses.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- is_signed  input  1  1 selects mult (two's complement), 0 selects multu; captured with start.
- A  input  WIDTH  multiplicand; captured with start.
- B  input  WIDTH  multiplier; captured with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; hi/lo are valid from this cycle on.
- hi  output  WIDTH  product bits [63:32].
- lo  output  WIDTH  product bits [31:0].

Behaviour:
- Reset is synchronous and active-high on clk. On reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, accumulator=0.
- States are IDLE, RUN and FIN.
- IDLE:
  - On start=1, capture mcand and mplr.
  - When is_signed=1, capture the magnitudes |A| and |B| and record neg = A[31]^B[31]. When is_signed=0, neg=0.
  - Clear the 33-bit upper accumulator (carry plus 32 bits), load the lower register with mplr, set counter=0, go to RUN.
- RUN (exactly WIDTH cycles):
  - If the lower register LSB is 1, set upper = upper + mcand using the adder; otherwise add 0.
  - Then shift {carry, upper, lower} right by 1 and increment the counter.
  - After the WIDTH-th RUN cycle (counter reaches WIDTH), go to FIN.
- FIN (1 cycle):
  - P = {upper, lower}. If neg=1, P = ~P + 1 (64-bit two's complement).
  - Register P into hi/lo, assert done for this cycle, return to IDLE.
- Latency:
  - start is sampled at edge 0.
  - busy=1 after edge 0 through the cycle in which done=1.
  - done=1 and hi/lo are updated after edge WIDTH+1, i.e. 33 cycles for WIDTH=32.
- busy and done are both high in the FIN cycle.
- A new start is accepted in the cycle after done (IDLE). Back-to-back throughput is one result per 34 cycles.
- start while busy (RUN or FIN) is ignored, with no effect on the operation in flight.
- hi/lo hold their last result until the next FIN. They are never partially updated.
- Signed edge case: 0x80000000 has magnitude 0x80000000 as unsigned 32-bit, which is correct. No overflow flag exists because the 64-bit product is always exact.
- Reset mid-operation aborts immediately and applies the reset values; done is not asserted.
- Zero operands go through the full 33 cycles; there is no early termination.

Decomposition:
- The state encodings (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and the WIDTH default go in the shared constants include file used by the datapath modules.
- Sub-module: the per-iteration addition instantiates the existing _32bit_adder, with carry-out forming accumulator bit 32.
- Magnitude and final negation use inverters plus that adder or a 64-bit increment built from it. No behavioural "*" operator.

Test Plan:
- Unsigned A=3, B=5, start 1 cycle -> done exactly 33 cycles later; hi=0x00000000, lo=0x0000000F; busy high for 33 cycles.
- Unsigned A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed same operands -> hi=0x00000000, lo=0x00000001.
- Signed A=-3 (0xFFFFFFFD), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Signed A=B=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Start 2+3 accepted, then start pulsed with A=9, B=9 at cycle 10 -> ignored; result hi=0, lo=6. A new start in the cycle after done is accepted and yields its own correct product.
- Reset asserted at cycle 15 of a RUN -> next cycle busy=0, done=0, hi=lo=0. A subsequent start with A=4, B=4 completes with lo=0x10 after 33 cycles.
- Random regression: 1000 signed and unsigned operand pairs compared against a 64-bit reference model; the checker also verifies that done pulses exactly once per accepted start.
